// File: rtl/voice_scheduler.sv
// Voice allocator: maps MIDI note events onto COUNT voice pipelines with
// release timing, per-voice age ranks and oldest-voice stealing.
package voice_scheduler_pkg;
  typedef enum logic {NOTE_OFF = 1'b0, NOTE_ON = 1'b1} note_en_t;
endpackage

module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int COUNT          = 4,
  parameter int RELEASE_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  input_en,
  input  note_en_t              note_in_en,
  input  logic [6:0]            note_in,
  input  logic [6:0]            velocity_in,
  output logic [COUNT-1:0]      voice_en,
  output logic [COUNT-1:0]      voice_gate,
  output logic [COUNT-1:0]      voice_retrigger,
  output logic [COUNT-1:0][6:0] notes_out,
  output logic [COUNT-1:0][6:0] velocities_out
);
  localparam int AW = $clog2(COUNT);
  localparam int TW = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [1:0] {V_FREE = 2'd0, V_ACTIVE = 2'd1, V_RELEASE = 2'd2} vstate_t;

  vstate_t        state_q [COUNT], state_d [COUNT];
  logic [AW-1:0]  age_q   [COUNT], age_d   [COUNT];
  logic [TW-1:0]  timer_q [COUNT], timer_d [COUNT];
  logic [6:0]     note_q  [COUNT], note_d  [COUNT];
  logic [6:0]     vel_q   [COUNT], vel_d   [COUNT];
  logic [COUNT-1:0] retrig_q, retrig_d;

  // input_en is a one-cycle strobe with no back-pressure: every strobed
  // event is consumed on the edge that samples it. ON with velocity 0 is OFF.
  logic is_on, is_off;
  assign is_on  = input_en && (note_in_en == NOTE_ON) && (velocity_in != 7'd0);
  assign is_off = input_en && !is_on;

  logic          act_hit, rel_hit, free_hit, ro_hit, ao_hit, off_hit;
  logic [AW-1:0] act_idx, rel_idx, free_idx, ro_idx, ao_idx, off_idx, sel_idx;
  logic [AW-1:0] old_age;

  always_comb begin
    act_hit = 1'b0; rel_hit = 1'b0; free_hit = 1'b0;
    ro_hit  = 1'b0; ao_hit  = 1'b0; off_hit  = 1'b0;
    act_idx = '0; rel_idx = '0; free_idx = '0;
    ro_idx  = '0; ao_idx  = '0; off_idx  = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (state_q[i] == V_ACTIVE) begin
        if (!act_hit && note_q[i] == note_in) begin act_hit = 1'b1; act_idx = AW'(i); end
        if (!ao_hit || age_q[i] > age_q[ao_idx]) begin ao_hit = 1'b1; ao_idx = AW'(i); end
      end
      if (state_q[i] == V_RELEASE) begin
        if (!rel_hit && note_q[i] == note_in) begin rel_hit = 1'b1; rel_idx = AW'(i); end
        if (!ro_hit || age_q[i] > age_q[ro_idx]) begin ro_hit = 1'b1; ro_idx = AW'(i); end
      end
      if (!free_hit && state_q[i] == V_FREE) begin free_hit = 1'b1; free_idx = AW'(i); end
    end
    off_hit = act_hit;
    off_idx = act_idx;
    if (act_hit)       sel_idx = act_idx;
    else if (rel_hit)  sel_idx = rel_idx;
    else if (free_hit) sel_idx = free_idx;
    else if (ro_hit)   sel_idx = ro_idx;
    else               sel_idx = ao_idx;
    old_age = age_q[sel_idx];
  end

  // An allocation takes precedence over a same-cycle release expiry.
  always_comb begin
    retrig_d = '0;
    for (int i = 0; i < COUNT; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      timer_d[i] = timer_q[i];
      note_d[i]  = note_q[i];
      vel_d[i]   = vel_q[i];
      if (is_on && sel_idx == AW'(i)) begin
        state_d[i]  = V_ACTIVE;
        age_d[i]    = '0;
        timer_d[i]  = '0;
        note_d[i]   = note_in;
        vel_d[i]    = velocity_in;
        retrig_d[i] = 1'b1;
      end else begin
        if (is_on && age_q[i] < old_age) age_d[i] = age_q[i] + 1'b1;
        if (is_off && off_hit && off_idx == AW'(i)) begin
          state_d[i] = V_RELEASE;
          timer_d[i] = TW'(RELEASE_CYCLES);
        end else if (state_q[i] == V_RELEASE) begin
          if (timer_q[i] == TW'(1)) begin
            state_d[i] = V_FREE;
            timer_d[i] = '0;
            note_d[i]  = '0;
            vel_d[i]   = '0;
          end else begin
            timer_d[i] = timer_q[i] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retrig_q <= '0;
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= V_FREE;
        age_q[i]   <= AW'(i);
        timer_q[i] <= '0;
        note_q[i]  <= '0;
        vel_q[i]   <= '0;
      end
    end else begin
      retrig_q <= retrig_d;
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
        timer_q[i] <= timer_d[i];
        note_q[i]  <= note_d[i];
        vel_q[i]   <= vel_d[i];
      end
    end
  end

  always_comb begin
    voice_retrigger = retrig_q;
    for (int i = 0; i < COUNT; i++) begin
      voice_en[i]       = (state_q[i] != V_FREE);
      voice_gate[i]     = (state_q[i] == V_ACTIVE);
      notes_out[i]      = note_q[i];
      velocities_out[i] = vel_q[i];
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed scenario bench for voice_scheduler (COUNT=4, RELEASE_CYCLES=8)
// with an expected-output queue per scenario.
module tb_voice_scheduler;
  import voice_scheduler_pkg::*;

  localparam int W = 68;

  logic             clk, reset, input_en;
  note_en_t         note_in_en;
  logic [6:0]       note_in, velocity_in;
  logic [3:0]       voice_en, voice_gate, voice_retrigger;
  logic [3:0][6:0]  notes_out, velocities_out;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp;
  logic [7:0]   ages;
  int n_cmp = 0;
  int n_err = 0;

  voice_scheduler #(.COUNT(4), .RELEASE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .input_en(input_en), .note_in_en(note_in_en),
    .note_in(note_in), .velocity_in(velocity_in), .voice_en(voice_en),
    .voice_gate(voice_gate), .voice_retrigger(voice_retrigger),
    .notes_out(notes_out), .velocities_out(velocities_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] mk(logic [3:0] en, logic [3:0] gate, logic [3:0] rt,
                                      logic [27:0] n, logic [27:0] v);
    return {en, gate, rt, n, v};
  endfunction

  function automatic logic [W-1:0] snap();
    return {voice_en, voice_gate, voice_retrigger, notes_out, velocities_out};
  endfunction

  function automatic logic [7:0] age_vec();
    return {dut.age_q[3], dut.age_q[2], dut.age_q[1], dut.age_q[0]};
  endfunction

  task automatic ev(input logic on, input logic [6:0] n, input logic [6:0] v);
    input_en = 1'b1; note_in_en = on ? NOTE_ON : NOTE_OFF;
    note_in = n; velocity_in = v;
    @(posedge clk); #1;
    input_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic fill4();
    ev(1, 7'd60, 7'd1); ev(1, 7'd62, 7'd2); ev(1, 7'd64, 7'd3); ev(1, 7'd65, 7'd4);
  endtask

  task automatic test_reset();
    reset = 1'b1; input_en = 1'b1; note_in_en = NOTE_ON; note_in = 7'd60; velocity_in = 7'd100;
    exp_q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 28'd0, 28'd0));
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 1'b0; input_en = 1'b0;
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    ages = age_vec(); n_cmp++;
    if (ages !== {2'd3, 2'd2, 2'd1, 2'd0}) begin
      n_err++; $display("FAIL reset_ages got=%h exp=%h", ages, {2'd3, 2'd2, 2'd1, 2'd0});
    end
  endtask

  task automatic test_alloc();
    logic [6:0] va, vb;
    va = 7'($urandom_range(1, 127)); vb = 7'($urandom_range(1, 127));
    do_reset();
    exp_q.push_back(mk(4'b0001, 4'b0001, 4'b0001, {21'd0, 7'd60}, {21'd0, va}));
    ev(1, 7'd60, va);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL alloc_first got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b0011, 4'b0011, 4'b0010, {14'd0, 7'd64, 7'd60}, {14'd0, vb, va}));
    ev(1, 7'd64, vb);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL alloc_second got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b0011, 4'b0011, 4'b0000, {14'd0, 7'd64, 7'd60}, {14'd0, vb, va}));
    idle(1);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL alloc_pulse_end got=%h exp=%h", got, exp); end
    ages = age_vec(); n_cmp++;
    if (ages[3:0] !== {2'd0, 2'd1}) begin
      n_err++; $display("FAIL alloc_ages got=%h exp=%h", ages[3:0], {2'd0, 2'd1});
    end
  endtask

  task automatic test_release();
    do_reset();
    ev(1, 7'd60, 7'd100);
    exp_q.push_back(mk(4'b0001, 4'b0000, 4'b0000, {21'd0, 7'd60}, {21'd0, 7'd100}));
    ev(0, 7'd60, 7'd0);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL release_gate_drop got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b0001, 4'b0000, 4'b0000, {21'd0, 7'd60}, {21'd0, 7'd100}));
    idle(7);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL release_hold_e7 got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 28'd0, 28'd0));
    idle(1);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL release_expire_e8 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_steal();
    do_reset();
    fill4();
    exp_q.push_back(mk(4'b1111, 4'b1111, 4'b0001, {7'd65, 7'd64, 7'd62, 7'd67},
                       {7'd4, 7'd3, 7'd2, 7'd50}));
    ev(1, 7'd67, 7'd50);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL steal_oldest got=%h exp=%h", got, exp); end
    ages = age_vec(); n_cmp++;
    if (ages !== {2'd1, 2'd2, 2'd3, 2'd0}) begin
      n_err++; $display("FAIL steal_ages got=%h exp=%h", ages, {2'd1, 2'd2, 2'd3, 2'd0});
    end
  endtask

  task automatic test_release_steal();
    do_reset();
    fill4();
    exp_q.push_back(mk(4'b1111, 4'b1011, 4'b0000, {7'd65, 7'd64, 7'd62, 7'd60},
                       {7'd4, 7'd3, 7'd2, 7'd1}));
    ev(0, 7'd64, 7'd0);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL relsteal_off got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b1111, 4'b1111, 4'b0100, {7'd65, 7'd70, 7'd62, 7'd60},
                       {7'd4, 7'd77, 7'd2, 7'd1}));
    ev(1, 7'd70, 7'd77);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL relsteal_pick got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ev(1, 7'd60, 7'd100);
    ev(0, 7'd60, 7'd0);
    idle(3);
    exp_q.push_back(mk(4'b0001, 4'b0001, 4'b0001, {21'd0, 7'd60}, {21'd0, 7'd50}));
    ev(1, 7'd60, 7'd50);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reuse_release got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b0001, 4'b0001, 4'b0000, {21'd0, 7'd60}, {21'd0, 7'd50}));
    idle(10);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reuse_timer_cleared got=%h exp=%h", got, exp); end
  endtask

  task automatic test_edges();
    do_reset();
    ev(1, 7'd60, 7'd100);
    exp_q.push_back(mk(4'b0001, 4'b0000, 4'b0000, {21'd0, 7'd60}, {21'd0, 7'd100}));
    ev(1, 7'd60, 7'd0);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL vel0_is_off got=%h exp=%h", got, exp); end
    do_reset();
    ev(1, 7'd60, 7'd100);
    exp_q.push_back(mk(4'b0001, 4'b0001, 4'b0000, {21'd0, 7'd60}, {21'd0, 7'd100}));
    ev(0, 7'd61, 7'd0);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL off_unmatched got=%h exp=%h", got, exp); end

    do_reset();
    fill4();
    ev(0, 7'd60, 7'd0);
    exp_q.push_back(mk(4'b1111, 4'b1110, 4'b0000, {7'd65, 7'd64, 7'd62, 7'd60},
                       {7'd4, 7'd3, 7'd2, 7'd1}));
    idle(7);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL expiry_pre got=%h exp=%h", got, exp); end
    exp_q.push_back(mk(4'b1111, 4'b1111, 4'b0001, {7'd65, 7'd64, 7'd62, 7'd70},
                       {7'd4, 7'd3, 7'd2, 7'd9}));
    ev(1, 7'd70, 7'd9);
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL expiry_on_wins got=%h exp=%h", got, exp); end

    do_reset();
    ev(1, 7'd60, 7'd100);
    ev(0, 7'd60, 7'd0);
    idle(2);
    exp_q.push_back(mk(4'b0000, 4'b0000, 4'b0000, 28'd0, 28'd0));
    do_reset();
    got = snap(); exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_mid_release got=%h exp=%h", got, exp); end
  endtask

  initial begin
    reset = 1'b0; input_en = 1'b0; note_in_en = NOTE_OFF;
    note_in = 7'd0; velocity_in = 7'd0;
    @(posedge clk); #1;
    test_reset();
    test_alloc();
    test_release();
    test_steal();
    test_release_steal();
    test_back_to_back();
    test_edges();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain left=%0d need=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Allocates the COUNT synthesis voice pipelines to incoming MIDI note events and sequences each voice through FREE -> ACTIVE -> RELEASE -> FREE.
- Differs from simple first-free allocation in three ways: a note-off keeps the voice sounding for a programmable release time, every voice carries an age rank, and the oldest voice is stolen when none is free.
- Sits between the MIDI decoder and the per-voice oscillator/envelope pipelines.

Parameters:
- COUNT, 4, number of voice pipelines; COUNT >= 2.
- RELEASE_CYCLES, 1024, number of clk cycles a voice stays in RELEASE after note-off; RELEASE_CYCLES >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- input_en  input  1  one-cycle strobe; note event valid this cycle.
- note_in_en  input  note_en_t  ON or OFF.
- note_in  input  7  MIDI note number.
- velocity_in  input  7  MIDI velocity.
- voice_en  output  COUNT  voice is ACTIVE or RELEASE; pipeline running.
- voice_gate  output  COUNT  voice is ACTIVE; envelope gate.
- voice_retrigger  output  COUNT  one-cycle pulse when a voice is (re)started by note-on.
- notes_out  output  COUNT x 7  note per voice.
- velocities_out  output  COUNT x 7  velocity per voice.

Behaviour:
- Reset (synchronous, active-high):
  - All voices FREE.
  - voice_en, voice_gate, voice_retrigger, notes_out, velocities_out = 0.
  - Age ranks = voice index (voice 0 newest). Release timers = 0.
  - Reset overrides a same-cycle input_en and a timer expiry.
- Per-voice state: FREE/ACTIVE/RELEASE (2 bits); age rank $clog2(COUNT) bits; release timer $clog2(RELEASE_CYCLES+1) bits.
- All outputs are registered. An event sampled at edge E is visible after E. voice_retrigger is high exactly one cycle.
- Event decode:
  - ON with velocity_in == 0 is treated as OFF.
  - All lookups use the state before the edge.
- ON, priority order (ties broken by lowest index):
  1. A voice ACTIVE with the same note: retrigger it, update velocity, age 0.
  2. A voice in RELEASE with the same note: return it to ACTIVE, update velocity, clear timer, age 0, retrigger.
  3. Lowest-index FREE voice.
  4. The RELEASE voice with the largest age (steal).
  5. The ACTIVE voice with the largest age (steal).
  - The selected voice gets note/velocity, becomes ACTIVE, age 0, retrigger pulse.
  - Every voice with age < the selected voice's old age increments its age by 1. The age set remains a permutation of 0..COUNT-1.
- OFF:
  - The ACTIVE voice with a matching note enters RELEASE; the timer is loaded with RELEASE_CYCLES.
  - No match among ACTIVE voices (including a match only in RELEASE or FREE): ignored, no state change.
  - note and velocity are held during RELEASE.
- Release timer:
  - Decrements each cycle while in RELEASE.
  - When the timer is 1 at an edge, the voice becomes FREE and notes_out/velocities_out for that voice clear to 0.
  - voice_en falls exactly RELEASE_CYCLES edges after the OFF edge.
  - Age is unchanged on expiry.
- Simultaneous expiry and ON:
  - An expiring voice counts as RELEASE for selection.
  - If selected, the ON allocation wins: the voice becomes ACTIVE, not FREE.
  - Otherwise the voice expires normally.
- Duplicate notes: a note is never held by two voices simultaneously (guaranteed by rules 1 and 2).
- input_en low: only timers advance. voice_retrigger = 0.

Test Plan:
- Reset then ON 60/v100, ON 64/v90 on consecutive cycles -> voice 0 = 60/100, voice 1 = 64/90; voice_gate = 0011; retrigger pulses 0001 then 0010; ages v1 = 0, v0 = 1.
- RELEASE_CYCLES = 8: ON 60, then OFF 60 at edge E -> voice_gate[0] drops after E; voice_en[0] drops after E+8; notes_out[0] = 0 at the same edge.
- Fill all 4 voices with ON 60, 62, 64, 65, then ON 67 -> voice 0 (oldest) stolen: notes_out[0] = 67, retrigger 0001, ages {0,3,2,1}.
- 4 ACTIVE, OFF 64 (voice 2), then ON 70 before the timer expires -> voice 2 stolen over the older ACTIVE voice 0; voice_gate = 1111.
- ON 60/v100, OFF 60, ON 60/v50 mid-release -> same voice reused, velocity 50, gate high, timer cleared, no second voice enabled.
- Edge cases: ON 60/v0 acts as OFF; OFF 61 with 61 not playing -> no change; ON on the exact expiry cycle of the sole RELEASE voice in a full set -> that voice is selected and stays enabled; reset asserted mid-release -> all outputs 0 next cycle.
